axi_lite_cmd_master: RTL and testbench

Upstream driver for `axi_lite_slave`: converts a simple one-at-a-time command/response interface into AXI-lite write-address, write-data, write-response, read-address and read-data handshakes. Firmware-side logic or a test sequencer issues single register reads and writes here. Only one transaction is in flight at a time. The port set mirrors the reduced AXI-lite channel set of `axi_lite_slave`: no strobes, no prot, no resp codes.

---
 rtl/axi_lite_cmd_master.sv | 207 ++++++++++++++++++++
 tb/tb_axi_lite_cmd_master.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_cmd_master.sv
// One-at-a-time command/response front end driving AXI-lite write and read channels.
// Optional watchdog abort is compiled in with `define AXI_CMD_TIMEOUT_EN.
module axi_lite_cmd_master #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              awvalid,
  output logic [ADDR_W-1:0] awaddr,
  input  logic              awready,
  output logic              wvalid,
  output logic [DATA_W-1:0] wdata,
  input  logic              wready,
  input  logic              bvalid,
  output logic              bready,
  output logic              arvalid,
  output logic [ADDR_W-1:0] araddr,
  input  logic              arready,
  input  logic              rvalid,
  input  logic [DATA_W-1:0] rdata,
  output logic              rready
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    WRESP = 3'd2,
    RADDR = 3'd3,
    RDATA = 3'd4,
    RSP   = 3'd5
  } state_t;

  state_t state_r;
  logic   aw_done_r;
  logic   w_done_r;
  logic   aw_hs_s;
  logic   w_hs_s;
  logic   timeout_s;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  assign aw_hs_s = awvalid & awready;
  assign w_hs_s  = wvalid & wready;

`ifdef AXI_CMD_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] cnt_r;

  // Watchdog: spans the whole transaction, saturates at the firing point.
  assign timeout_s = (cnt_r >= CNT_W'(TIMEOUT_CYCLES - 1));

  // Transaction-wide cycle counter, cleared while idle (i.e. on accept).
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= '0;
    end else if (state_r == IDLE) begin
      cnt_r <= '0;
    end else if ((state_r == WR) || (state_r == WRESP) ||
                 (state_r == RADDR) || (state_r == RDATA)) begin
      cnt_r <= timeout_s ? cnt_r : cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= cnt_r;
    end
  end
`else
  assign timeout_s = 1'b0;
`endif

  // Main FSM; every output is a register updated here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      aw_done_r <= 1'b0;
      w_done_r  <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_write <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      awvalid   <= 1'b0;
      awaddr    <= '0;
      wvalid    <= 1'b0;
      wdata     <= '0;
      bready    <= 1'b0;
      arvalid   <= 1'b0;
      araddr    <= '0;
      rready    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            rsp_write <= cmd_write;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            aw_done_r <= 1'b0;
            w_done_r  <= 1'b0;
            if (cmd_write) begin
              awaddr  <= cmd_addr;
              wdata   <= cmd_wdata;
              awvalid <= 1'b1;
              wvalid  <= 1'b1;
              state_r <= WR;
            end else begin
              araddr  <= cmd_addr;
              arvalid <= 1'b1;
              state_r <= RADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        WR: begin
          if (aw_hs_s) begin
            awvalid   <= 1'b0;
            aw_done_r <= 1'b1;
          end
          if (w_hs_s) begin
            wvalid   <= 1'b0;
            w_done_r <= 1'b1;
          end
          // A completing handshake wins over a simultaneous watchdog expiry.
          if ((aw_done_r || aw_hs_s) && (w_done_r || w_hs_s)) begin
            bready  <= 1'b1;
            state_r <= WRESP;
          end else if (timeout_s) begin
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_r   <= RSP;
          end
        end
        WRESP: begin
          if (bvalid) begin
            bready    <= 1'b0;
            rsp_rdata <= '0;
            rsp_valid <= 1'b1;
            state_r   <= RSP;
          end else if (timeout_s) begin
            bready    <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_r   <= RSP;
          end
        end
        RADDR: begin
          if (arready) begin
            arvalid <= 1'b0;
            rready  <= 1'b1;
            state_r <= RDATA;
          end else if (timeout_s) begin
            arvalid   <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_r   <= RSP;
          end
        end
        RDATA: begin
          if (rvalid) begin
            rready    <= 1'b0;
            rsp_rdata <= rdata;
            rsp_valid <= 1'b1;
            state_r   <= RSP;
          end else if (timeout_s) begin
            rready    <= 1'b0;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state_r   <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end
        end
        default: begin
          state_r   <= IDLE;
          cmd_ready <= 1'b0;
          rsp_valid <= 1'b0;
          awvalid   <= 1'b0;
          wvalid    <= 1'b0;
          bready    <= 1'b0;
          arvalid   <= 1'b0;
          rready    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// Scoreboard bench for axi_lite_cmd_master: randomized commands, a delay-programmable
// AXI-lite slave, and a memory reference model that predicts every response.
module tb_axi_lite_cmd_master;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic rsp_valid, rsp_ready, rsp_write, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic awvalid, awready, wvalid, wready, bvalid, bready;
  logic arvalid, arready, rvalid, rready;
  logic [AW-1:0] awaddr, araddr;
  logic [DW-1:0] wdata, rdata;

  always #5 clk = ~clk;

  axi_lite_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .bvalid(bvalid), .bready(bready),
    .arvalid(arvalid), .araddr(araddr), .arready(arready),
    .rvalid(rvalid), .rdata(rdata), .rready(rready)
  );

  int tests = 0;
  int fails = 0;

  typedef struct packed {
    logic        w;
    logic [31:0] d;
    logic        e;
  } exp_t;
  exp_t exp_q[$];
  bit [31:0] model_mem [bit [31:0]];
  bit [31:0] slv_mem [bit [31:0]];

  int aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
  bit ar_never = 1'b0;
  bit allow_abort = 1'b0;
  int rr_mode = 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s: bound expired or unexpected event at %0t", name, $time);
  endtask

  // AXI-lite slave with programmable per-channel latencies
  initial begin
    bit s_aw, s_w, s_b, s_ar, s_r, s_rst;
    bit have_aw, have_w, b_pend, r_pend;
    logic [31:0] s_awaddr, s_wdata, s_araddr, aw_a, w_d, r_a;
    int aw_cnt, w_cnt, ar_cnt, b_cnt, r_cnt;
    have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
    aw_cnt = 0; w_cnt = 0; ar_cnt = 0; b_cnt = 0; r_cnt = 0;
    aw_a = '0; w_d = '0; r_a = '0;
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0;
    rvalid = 1'b0; rdata = '0;
    forever begin
      @(negedge clk);
      s_rst = rst;
      s_aw = awvalid && awready; s_awaddr = awaddr;
      s_w  = wvalid && wready;   s_wdata  = wdata;
      s_b  = bvalid && bready;
      s_ar = arvalid && arready; s_araddr = araddr;
      s_r  = rvalid && rready;
      @(posedge clk);
      #1;
      if (s_rst) begin
        have_aw = 0; have_w = 0; b_pend = 0; r_pend = 0;
        aw_cnt = 0; w_cnt = 0; ar_cnt = 0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; arready = 1'b0; rvalid = 1'b0;
      end else begin
        if (s_aw) begin have_aw = 1; aw_a = s_awaddr; end
        if (s_w)  begin have_w = 1;  w_d = s_wdata; end
        if (have_aw && have_w) begin
          slv_mem[aw_a] = w_d;
          have_aw = 0; have_w = 0; b_pend = 1; b_cnt = 0;
        end
        if (s_b) bvalid = 1'b0;
        if (b_pend) begin
          if (b_cnt >= b_dly) begin bvalid = 1'b1; b_pend = 0; end
          else b_cnt++;
        end
        if (s_ar) begin r_pend = 1; r_a = s_araddr; r_cnt = 0; end
        if (s_r) rvalid = 1'b0;
        if (r_pend) begin
          if (r_cnt >= r_dly) begin
            rvalid = 1'b1;
            rdata = slv_mem.exists(r_a) ? slv_mem[r_a] : 32'h0;
            r_pend = 0;
          end else r_cnt++;
        end
        if (awvalid) begin awready = (aw_cnt >= aw_dly); aw_cnt++; end
        else begin awready = 1'b0; aw_cnt = 0; end
        if (wvalid) begin wready = (w_cnt >= w_dly); w_cnt++; end
        else begin wready = 1'b0; w_cnt = 0; end
        if (arvalid) begin arready = !ar_never && (ar_cnt >= ar_dly); ar_cnt++; end
        else begin arready = 1'b0; ar_cnt = 0; end
      end
    end
  end

  // Response consumer: random, always-ready or stalled
  initial begin
    rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      case (rr_mode)
        0:       rsp_ready = ($urandom_range(0, 2) != 0);
        1:       rsp_ready = 1'b1;
        default: rsp_ready = 1'b0;
      endcase
    end
  end

  // Monitor: protocol stability checks and scoreboard pop
  initial begin
    logic p_rst, p_awv, p_awhs, p_wv, p_whs, p_arv, p_arhs, p_rspv, p_rspr, p_rw, p_re;
    logic [31:0] p_awaddr, p_wdata, p_araddr, p_rd;
    exp_t e;
    p_rst = 1; p_awv = 0; p_awhs = 0; p_wv = 0; p_whs = 0; p_arv = 0; p_arhs = 0;
    p_rspv = 0; p_rspr = 0; p_rw = 0; p_re = 0;
    p_awaddr = '0; p_wdata = '0; p_araddr = '0; p_rd = '0;
    forever begin
      @(negedge clk);
      if (!p_rst) begin
        if (!allow_abort && p_awv && !p_awhs) check("aw_hold", {awvalid, awaddr}, {1'b1, p_awaddr});
        if (!allow_abort && p_wv && !p_whs)   check("w_hold", {wvalid, wdata}, {1'b1, p_wdata});
        if (!allow_abort && p_arv && !p_arhs) check("ar_hold", {arvalid, araddr}, {1'b1, p_araddr});
        if (p_awhs) check("aw_drop", awvalid, 1'b0);
        if (p_whs)  check("w_drop", wvalid, 1'b0);
        if (p_arhs) check("ar_drop", arvalid, 1'b0);
        if (p_rspv && !p_rspr)
          check("rsp_stable", {rsp_valid, rsp_write, rsp_err, rsp_rdata}, {1'b1, p_rw, p_re, p_rd});
      end
      if (rsp_valid) check("cmd_ready_in_rsp", cmd_ready, 1'b0);
      if (rsp_valid && rsp_ready) begin
        if (exp_q.size() == 0) flag_fail("unexpected_rsp");
        else begin
          e = exp_q.pop_front();
          check("rsp_write", rsp_write, e.w);
          check("rsp_rdata", rsp_rdata, e.d);
          check("rsp_err", rsp_err, e.e);
        end
      end
      p_rst = rst;
      p_awv = awvalid; p_awhs = awvalid && awready; p_awaddr = awaddr;
      p_wv = wvalid; p_whs = wvalid && wready; p_wdata = wdata;
      p_arv = arvalid; p_arhs = arvalid && arready; p_araddr = araddr;
      p_rspv = rsp_valid; p_rspr = rsp_ready; p_rw = rsp_write; p_re = rsp_err; p_rd = rsp_rdata;
    end
  end

  // Issue one command from posedge+1; returns one step after the accepting edge
  task automatic issue(input bit wr, input bit [31:0] a, input bit [31:0] d,
                       input bit expect_rsp, input bit exp_err);
    int n;
    bit got;
    exp_t e;
    n = 0; got = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_wdata = d;
    while (!got && n < 200) begin
      @(negedge clk);
      if (cmd_ready) got = 1;
      n++;
    end
    if (!got) flag_fail("cmd_accept");
    else if (expect_rsp) begin
      if (exp_err) e = '{w: wr, d: 32'h0, e: 1'b1};
      else if (wr) begin
        model_mem[a] = d;
        e = '{w: 1'b1, d: 32'h0, e: 1'b0};
      end else e = '{w: 1'b0, d: (model_mem.exists(a) ? model_mem[a] : 32'h0), e: 1'b0};
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_addr = $urandom; cmd_wdata = $urandom; cmd_write = $urandom_range(0, 1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
    if (exp_q.size() != 0) begin flag_fail("rsp_missing"); exp_q.delete(); end
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit [31:0] v10, v30;
    int n;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, rsp_write}, 9'h0);
    check("reset_addr", {awaddr, araddr}, 64'h0);
    check("reset_data", {wdata, rsp_rdata}, 64'h0);
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); @(negedge clk);
    check("cmd_ready_after_reset", cmd_ready, 1'b1);
    @(posedge clk); #1;

    // Zero-wait write, cycle-accurate
    issue(1'b1, 32'h0, 32'hDEADBEEF, 1'b1, 1'b0);
    @(negedge clk);
    check("wr_n1_valids", {awvalid, wvalid, awready, wready}, 4'hF);
    check("wr_n1_addr_data", {awaddr, wdata}, {32'h0, 32'hDEADBEEF});
    @(negedge clk);
    check("wr_n2_bready", {awvalid, wvalid, bready}, 3'b001);
    @(negedge clk);
    check("wr_n3_rsp", {rsp_valid, rsp_write, rsp_err}, 3'b110);
    @(negedge clk);
    check("wr_b2b_cmd_ready", {cmd_ready, rsp_valid}, 2'b10);
    @(posedge clk); #1;

    // Zero-wait read of the same address
    issue(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    check("rd_n1_ar", {arvalid, arready, araddr}, {2'b11, 32'h0});
    @(negedge clk);
    check("rd_n2_rready", {arvalid, rready}, 2'b01);
    @(negedge clk);
    check("rd_n3_rsp", {rsp_valid, rsp_write, rsp_rdata}, {2'b10, 32'hDEADBEEF});
    @(posedge clk); #1;

    // W completes 3 cycles before AW
    aw_dly = 3;
    v10 = $urandom;
    issue(1'b1, 32'h10, v10, 1'b1, 1'b0);
    wait_idle();
    aw_dly = 0;
    repeat (3) @(posedge clk);
    #1;

    // Stalled response consumer
    rr_mode = 2;
    issue(1'b0, 32'h10, 32'h0, 1'b1, 1'b0);
    n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    if (!rsp_valid) flag_fail("stall_rsp_valid");
    repeat (5) begin
      @(negedge clk);
      check("stall_hold", {rsp_valid, cmd_ready, rsp_rdata}, {2'b10, v10});
    end
    @(posedge clk); #1; rr_mode = 1;
    @(negedge clk);
    @(negedge clk);
    check("stall_cmd_ready_after", {cmd_ready, rsp_valid}, 2'b10);
    @(posedge clk); #1;

`ifdef AXI_CMD_TIMEOUT_EN
    allow_abort = 1'b1; ar_never = 1'b1;
    issue(1'b0, 32'h20, 32'h0, 1'b1, 1'b1);
    n = 0;
    @(negedge clk);
    while (arvalid && n < 50) begin n++; @(negedge clk); end
    check("timeout_ar_cycles", n, TO);
    wait_idle();
    ar_never = 1'b0; allow_abort = 1'b0;
`endif

    // Reset while AW/W are outstanding
    aw_dly = 10; w_dly = 10;
    issue(1'b1, 32'h30, $urandom, 1'b0, 1'b0);
    @(negedge clk); @(negedge clk);
    check("pre_reset_awvalid", {awvalid, wvalid}, 2'b11);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("abort_ctrl", {cmd_ready, awvalid, wvalid, bready, arvalid, rready, rsp_valid, rsp_err, rsp_write}, 9'h0);
    check("abort_data", {awaddr, wdata}, 64'h0);
    @(posedge clk); #1; rst = 1'b0; aw_dly = 0; w_dly = 0;
    v30 = $urandom;
    issue(1'b1, 32'h30, v30, 1'b1, 1'b0);
    wait_idle();
    issue(1'b0, 32'h30, 32'h0, 1'b1, 1'b0);
    wait_idle();

    // Randomized traffic
    rr_mode = 0;
    for (int i = 0; i < 40; i++) begin
      aw_dly = $urandom_range(0, 2); w_dly = $urandom_range(0, 2);
      ar_dly = $urandom_range(0, 2); b_dly = $urandom_range(0, 2); r_dly = $urandom_range(0, 2);
      issue($urandom_range(0, 1), {27'h0, 3'($urandom_range(0, 7)), 2'b00}, $urandom, 1'b1, 1'b0);
    end
    wait_idle();
    repeat (5) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

endmodule
